// File: rtl/phase_ctrl_pkg.sv
// rtl/phase_ctrl_pkg.sv - shared constants for the phase-capture sequencer
// Contents: FSM state encoding, default timestamp width, first_sel encodings.
package phase_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 32;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_WAIT2   = 3'd2;
  localparam logic [2:0] ST_REPORT  = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  localparam logic FIRST_SEL_SIG1 = 1'b0;  // signal_1 first, or both together
  localparam logic FIRST_SEL_SIG2 = 1'b1;  // signal_2 first

endpackage

// File: rtl/phase_capture_ctrl_if.sv
// rtl/phase_capture_ctrl_if.sv - CPU-side control/result bundle of the phase-capture sequencer
// Signals:
//   arm, abort, result_ack            CPU -> sequencer
//   time_1, time_2, delta (CNT_W)     sequencer -> CPU result fields
//   first_sel, result_valid, timeout  sequencer -> CPU result qualifiers
//   busy, state_dbg (3)               sequencer -> CPU status
// Modports: master (CPU / bench side), slave (sequencer side).
interface phase_capture_ctrl_if
  import phase_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) ();

  logic             arm;
  logic             abort;
  logic             result_ack;
  logic [CNT_W-1:0] time_1;
  logic [CNT_W-1:0] time_2;
  logic [CNT_W-1:0] delta;
  logic             first_sel;
  logic             result_valid;
  logic             timeout;
  logic             busy;
  logic [2:0]       state_dbg;

  modport master (
    output arm, abort, result_ack,
    input  time_1, time_2, delta, first_sel, result_valid, timeout, busy, state_dbg
  );

  modport slave (
    input  arm, abort, result_ack,
    output time_1, time_2, delta, first_sel, result_valid, timeout, busy, state_dbg
  );

endinterface

// File: rtl/phc_edge_sync.sv
// rtl/phc_edge_sync.sv - 2-FF synchroniser, optional high-time filter and rising-edge pulse
// Optional feature macro: PHC_DEGLITCH_EN (input must stay high DEGLITCH_CYCLES cycles)
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   sig_in       raw asynchronous input
//   edge_pulse   one-cycle registered pulse; 3 cycles after the input rises without the
//                filter, 3 + DEGLITCH_CYCLES - 1 cycles with it
module phc_edge_sync #(
  parameter int DEGLITCH_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic edge_pulse
);

  if (DEGLITCH_CYCLES < 1) begin : g_bad_deglitch
    $error("phc_edge_sync: DEGLITCH_CYCLES must be at least 1");
  end

  logic sync1_q, sync2_q;
  logic edge_q, edge_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PHC_DEGLITCH_EN
  localparam int HW = $clog2(DEGLITCH_CYCLES + 1);

  // Counts consecutive synchronised-high cycles; saturates so the pulse fires once per pulse.
  logic [HW-1:0] high_cnt_q, high_cnt_d;

  always_comb begin
    high_cnt_d = high_cnt_q;
    if (!sync2_q) begin
      high_cnt_d = '0;
    end else if (high_cnt_q != HW'(DEGLITCH_CYCLES)) begin
      high_cnt_d = high_cnt_q + HW'(1);
    end
    edge_d = sync2_q && (high_cnt_q == HW'(DEGLITCH_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt_q <= '0;
      edge_q     <= 1'b0;
    end else begin
      high_cnt_q <= high_cnt_d;
      edge_q     <= edge_d;
    end
  end
`else
  logic sync3_q;

  always_comb begin
    edge_d = sync2_q & ~sync3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync3_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync3_q <= sync2_q;
      edge_q  <= edge_d;
    end
  end
`endif

  assign edge_pulse = edge_q;

endmodule

// File: rtl/phase_capture_ctrl.sv
// rtl/phase_capture_ctrl.sv - armed one-shot two-channel edge timestamp sequencer
// Optional feature macro: PHC_DEGLITCH_EN (high-time qualification inside phc_edge_sync)
// Ports:
//   sysclk            clock (clk2 domain)
//   sysreset_n        asynchronous reset, active low
//   signal_1/signal_2 raw asynchronous mic pulses
//   bus               phase_capture_ctrl_if.slave: arm, abort, result_ack in;
//                     time_1, time_2, delta, first_sel, result_valid, timeout, busy,
//                     state_dbg out
module phase_capture_ctrl
  import phase_ctrl_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEFAULT,
  parameter int TIMEOUT_CYCLES  = 65536,
  parameter int HOLDOFF_CYCLES  = 2500000,
  parameter int DEGLITCH_CYCLES = 4
) (
  input  logic                 sysclk,
  input  logic                 sysreset_n,
  input  logic                 signal_1,
  input  logic                 signal_2,
  phase_capture_ctrl_if.slave  bus
);

  logic edge_1, edge_2;

  phc_edge_sync #(.DEGLITCH_CYCLES(DEGLITCH_CYCLES)) u_sync_1 (
    .clk        (sysclk),
    .rst_n      (sysreset_n),
    .sig_in     (signal_1),
    .edge_pulse (edge_1)
  );

  phc_edge_sync #(.DEGLITCH_CYCLES(DEGLITCH_CYCLES)) u_sync_2 (
    .clk        (sysclk),
    .rst_n      (sysreset_n),
    .sig_in     (signal_2),
    .edge_pulse (edge_2)
  );

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      tmo_q, tmo_d;
  logic [31:0]      hold_q, hold_d;
  logic [CNT_W-1:0] time_1_q, time_1_d;
  logic [CNT_W-1:0] time_2_q, time_2_d;
  logic [CNT_W-1:0] delta_q, delta_d;
  logic             first_sel_q, first_sel_d;
  logic             result_valid_q, result_valid_d;
  logic             timeout_q, timeout_d;
  logic             other_edge;

  // In WAIT2 only the channel that has not yet fired can complete the pair.
  assign other_edge = (first_sel_q == FIRST_SEL_SIG1) ? edge_2 : edge_1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + CNT_W'(1);
    tmo_d          = tmo_q;
    hold_d         = hold_q;
    time_1_d       = time_1_q;
    time_2_d       = time_2_q;
    delta_d        = delta_q;
    first_sel_d    = first_sel_q;
    result_valid_d = result_valid_q;
    timeout_d      = timeout_q;

    if (bus.abort) begin
      // Result fields are kept for post-mortem reads; only the qualifiers are dropped.
      state_d        = ST_IDLE;
      result_valid_d = 1'b0;
      timeout_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.arm) begin
            state_d        = ST_ARMED;
            result_valid_d = 1'b0;
            timeout_d      = 1'b0;
          end
        end
        ST_ARMED: begin
          if (edge_1 && edge_2) begin
            time_1_d    = cnt_q;
            time_2_d    = cnt_q;
            first_sel_d = FIRST_SEL_SIG1;
            state_d     = ST_REPORT;
          end else if (edge_1) begin
            time_1_d    = cnt_q;
            first_sel_d = FIRST_SEL_SIG1;
            tmo_d       = '0;
            state_d     = ST_WAIT2;
          end else if (edge_2) begin
            time_2_d    = cnt_q;
            first_sel_d = FIRST_SEL_SIG2;
            tmo_d       = '0;
            state_d     = ST_WAIT2;
          end
        end
        ST_WAIT2: begin
          if (other_edge) begin
            if (first_sel_q == FIRST_SEL_SIG1) time_2_d = cnt_q;
            else                               time_1_d = cnt_q;
            state_d = ST_REPORT;
          end else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            if (first_sel_q == FIRST_SEL_SIG1) time_2_d = '0;
            else                               time_1_d = '0;
            state_d = ST_REPORT;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end
        ST_REPORT: begin
          // First REPORT cycle publishes; afterwards wait for the CPU to take it.
          if (!result_valid_q) begin
            result_valid_d = 1'b1;
            delta_d        = timeout_q ? '0 : (time_2_q - time_1_q);
          end else if (bus.result_ack) begin
            result_valid_d = 1'b0;
            hold_d         = '0;
            state_d        = (HOLDOFF_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (hold_q == 32'(HOLDOFF_CYCLES - 1)) state_d = ST_IDLE;
          else                                   hold_d  = hold_q + 32'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      tmo_q          <= '0;
      hold_q         <= '0;
      time_1_q       <= '0;
      time_2_q       <= '0;
      delta_q        <= '0;
      first_sel_q    <= 1'b0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tmo_q          <= tmo_d;
      hold_q         <= hold_d;
      time_1_q       <= time_1_d;
      time_2_q       <= time_2_d;
      delta_q        <= delta_d;
      first_sel_q    <= first_sel_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  assign bus.time_1       = time_1_q;
  assign bus.time_2       = time_2_q;
  assign bus.delta        = delta_q;
  assign bus.first_sel    = first_sel_q;
  assign bus.result_valid = result_valid_q;
  assign bus.timeout      = timeout_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.state_dbg    = state_q;

endmodule
